// File: rtl/seven_segment_scan.sv
// Multiplexed hex seven-segment scanner with frame-synchronous double buffering.
// Optional leading-zero suppression: define LEADING_ZERO_BLANK_EN.
module seven_segment_scan #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 100000,
  parameter bit AN_ACTIVE_LOW = 1'b1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done
);

  localparam int                    TICK_W    = $clog2(REFRESH_DIV);
  localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW}};

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
  } frame_t;

  frame_t                  shadow_q, shadow_d, active_q, active_d;
  logic [TICK_W-1:0]       tick_q, tick_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;
  logic                    tick_last, wrap;
  logic [3:0]              nibble;
  logic                    dp_sel, blank_sel;
  logic [NUM_DIGITS-1:0]   onehot, auto_blank;
`ifdef LEADING_ZERO_BLANK_EN
  logic                    lz_run;
`endif

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0:    glyph = 7'b0000001;
      4'h1:    glyph = 7'b1001111;
      4'h2:    glyph = 7'b0010010;
      4'h3:    glyph = 7'b0000110;
      4'h4:    glyph = 7'b1001100;
      4'h5:    glyph = 7'b0100100;
      4'h6:    glyph = 7'b0100000;
      4'h7:    glyph = 7'b0001111;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0000100;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b1100000;
      4'hC:    glyph = 7'b0110001;
      4'hD:    glyph = 7'b1000010;
      4'hE:    glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  assign tick_last = (tick_q == TICK_LAST);
  assign wrap      = en && tick_last && (idx_q == IDX_LAST);

  // Leading-zero run scans from the top digit down; digit 0 always shows.
  always_comb begin
    auto_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    lz_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (lz_run && (active_q.value[4*i +: 4] == 4'h0) && !active_q.dp[i]) begin
        auto_blank[i] = 1'b1;
      end else begin
        lz_run = 1'b0;
      end
    end
`endif
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    tick_d       = tick_q;
    idx_d        = idx_q;
    nibble       = 4'h0;
    dp_sel       = 1'b0;
    blank_sel    = 1'b0;
    onehot       = '0;
    frame_done_d = wrap;

    if (en) begin
      tick_d = tick_last ? '0 : tick_q + 1'b1;
      if (tick_last) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
    end

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nibble    = active_q.value[4*i +: 4];
        dp_sel    = active_q.dp[i];
        blank_sel = active_q.blank[i] | auto_blank[i];
        onehot[i] = 1'b1;
      end
    end

    // A load on the wrap cycle reaches the active copy through shadow_d.
    shadow_d = load ? frame_t'{value: value, dp: dp_in, blank: blank} : shadow_q;
    active_d = wrap ? shadow_d : active_q;

    if (!en) begin
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      an_d  = AN_OFF;
    end else begin
      seg_d = blank_sel ? 7'h7F : glyph(nibble);
      dp_d  = blank_sel | ~dp_sel;
      an_d  = onehot ^ AN_OFF;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q       <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/seven_segment_scan.md
SEVEN_SEGMENT_SCAN -- requirements
Module: seven_segment_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (range 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clock cycles each digit is driven (range 2..2^24).
REQ-003 SHALL have parameter AN_ACTIVE_LOW, default 1, anode polarity (1 = low enables digit).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en  input  1  scan enable.
REQ-007 SHALL have port load  input  1  capture strobe for value/dp_in/blank.
REQ-008 SHALL have port value  input  4*NUM_DIGITS  hex nibbles; nibble i = digit i, digit 0 = least significant.
REQ-009 SHALL have port dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-010 SHALL have port blank  input  NUM_DIGITS  per-digit force blank, 1 = blank.
REQ-011 SHALL have port seg  output  7  segments a..g on seg[6]..seg[0], active low.
REQ-012 SHALL have port dp  output  1  decimal point, active low.
REQ-013 SHALL have port an  output  NUM_DIGITS  one-hot digit enable, polarity per AN_ACTIVE_LOW.
REQ-014 SHALL have port digit_idx  output  $clog2(NUM_DIGITS) (min 1)  index of digit currently driven.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse when scan wraps to digit 0.

Function
REQ-016 SHALL hold a tick counter 0..REFRESH_DIV-1 incrementing each cycle while en=1; at REFRESH_DIV-1 it SHALL wrap to 0 and advance digit_idx.
REQ-017 digit_idx SHALL step 0,1,...,NUM_DIGITS-1 then wrap to 0; frame_done SHALL be 1 for exactly the cycle in which digit_idx wraps to 0.
REQ-018 seg, dp, an SHALL be registered and reflect digit_idx with one cycle latency; all outputs glitch-free (no combinational path from inputs).
REQ-019 Glyphs SHALL be hex 0-F active low: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-020 load=1 SHALL capture value/dp_in/blank into a shadow register; the active register SHALL copy shadow only on digit_idx wrap (frame boundary), preventing tearing.
REQ-021 Multiple load pulses within one frame: last SHALL win; load coincident with the wrap cycle SHALL pass inputs straight into the active register that cycle.
REQ-022 Blanked digit SHALL drive seg=1111111 and dp=1 while its anode still asserts.
REQ-023 en=0 SHALL freeze tick counter and digit_idx, deassert all anodes next cycle, suppress frame_done; load still captures; en reassert resumes from frozen state.

Reset
REQ-024 rst=1 SHALL asynchronously set tick=0, digit_idx=0, shadow and active registers=0, seg=1111111, dp=1, an all inactive, frame_done=0.
REQ-025 Reset asserted mid-frame SHALL discard pending shadow data; first anode asserts one cycle after rst deasserts with en=1.

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN defined: digits from NUM_DIGITS-1 downward with nibble 0 SHALL be blanked until the first non-zero nibble; digit 0 never auto-blanked; dp_in=1 on a digit stops blanking at that digit.
REQ-027 Macro undefined: zero nibbles SHALL display "0"; only blank input blanks.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, AN_ACTIVE_LOW=1)
REQ-028 Reset release, en=1, load value=16'h1234 -> after next wrap, an cycles 1110,1101,1011,0111 every 4 clocks with seg 1001100(4),0000110(3),0010010(2),1001111(1).
REQ-029 Free run -> frame_done pulses exactly once every 16 clocks, coincident with digit_idx 3->0.
REQ-030 load 16'hABCD mid-frame then 16'h00EF later same frame -> display changes only at wrap, showing EF (digits 0,1 = 0111000, 0110000).
REQ-031 value=16'h0005 -> with LEADING_ZERO_BLANK_EN digits 3..1 seg=1111111, digit 0 = 0100100; without macro digits 3..1 = 0000001.
REQ-032 en=0 at digit 2 for 10 clocks -> an=1111, digit_idx holds 2, no frame_done; en=1 resumes at digit 2.
REQ-033 rst pulsed mid-frame after load -> seg=1111111, an=1111, dp=1 immediately, displayed value 0 after release.
